// File: rtl/muldiv_unit.sv
// Iterative radix-2 multiply/divide unit with architectural HI/LO registers.
// One shift-add or restoring-subtract step per cycle; signs are fixed up in a final cycle.
module muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int CNTW  = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] srcA,
  input  logic [WIDTH-1:0] srcB,
  input  logic             flush,
  input  logic             wr_hi,
  input  logic             wr_lo,
  input  logic [WIDTH-1:0] wdata,
  input  logic             rd_hilo,
  output logic             busy,
  output logic             done,
  output logic             stall_req,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;
  localparam logic [CNTW-1:0] LAST = CNTW'(WIDTH - 1);

  state_t             state_q, state_d;
  logic [CNTW-1:0]    cnt_q, cnt_d;
  logic [1:0]         op_q, op_d;
  logic [WIDTH-1:0]   b_q, b_d, rawa_q, rawa_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic               neg_res_q, neg_res_d, neg_rem_q, neg_rem_d, dz_q, dz_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic               done_q, done_d;

  logic               sgn_a, sgn_b;
  logic [WIDTH-1:0]   abs_a, abs_b;
  logic [WIDTH:0]     mul_sum, div_rem, div_diff;
  logic               qbit;
  logic [2*WIDTH-1:0] mul_next, div_next, prod;
  logic [WIDTH-1:0]   quo, rem;

  assign sgn_a = op[0] & srcA[WIDTH-1];
  assign sgn_b = op[0] & srcB[WIDTH-1];
  assign abs_a = sgn_a ? -srcA : srcA;
  assign abs_b = sgn_b ? -srcB : srcB;

  // Multiply: acc = {partial product, remaining multiplier bits}
  assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? b_q : {WIDTH{1'b0}})};
  assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

  // Divide: acc = {partial remainder, dividend bits shifting into quotient}
  assign div_rem  = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign div_diff = div_rem - {1'b0, b_q};
  assign qbit     = ~div_diff[WIDTH];
  assign div_next = {(qbit ? div_diff[WIDTH-1:0] : div_rem[WIDTH-1:0]), acc_q[WIDTH-2:0], qbit};

  assign prod = neg_res_q ? -acc_q : acc_q;
  assign quo  = neg_res_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
  assign rem  = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    b_d       = b_q;
    rawa_d    = rawa_q;
    acc_d     = acc_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    dz_d      = dz_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && !flush) begin
          state_d   = CALC;
          cnt_d     = '0;
          op_d      = op;
          b_d       = abs_b;
          rawa_d    = srcA;
          acc_d     = {{WIDTH{1'b0}}, abs_a};
          neg_res_d = sgn_a ^ sgn_b;
          neg_rem_d = sgn_a;
          dz_d      = op[1] && (srcB == '0);
        end else if (!start) begin
          if (wr_hi) hi_d = wdata;
          if (wr_lo) lo_d = wdata;
        end
      end
      CALC: begin
        if (flush) state_d = IDLE;
        else begin
          acc_d = op_q[1] ? div_next : mul_next;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST) state_d = FIX;
        end
      end
      FIX: begin
        state_d = IDLE;
        if (!flush) begin
          done_d = 1'b1;
          if (dz_q) begin
            hi_d = rawa_q;
            lo_d = '1;
          end else if (op_q[1]) begin
            hi_d = rem;
            lo_d = quo;
          end else begin
            hi_d = prod[2*WIDTH-1:WIDTH];
            lo_d = prod[WIDTH-1:0];
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      op_q      <= '0;
      b_q       <= '0;
      rawa_q    <= '0;
      acc_q     <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      dz_q      <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      b_q       <= b_d;
      rawa_q    <= rawa_d;
      acc_q     <= acc_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      dz_q      <= dz_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
    end
  end

  assign busy      = (state_q != IDLE);
  assign stall_req = rd_hilo & busy;
  assign done      = done_q;
  assign hi        = hi_q;
  assign lo        = lo_q;
endmodule
